conv_a1_accumulate_relu: RTL and testbench
==========================================

Name: conv_a1_accumulate_relu

Overview:
- Downstream of the NUMBER_OF_UNITS parallel C1 convolution units.
- Each cycle it sums their per-channel partial results for one output pixel, adds the per-filter bias, applies ReLU with saturation, and writes the result into the next-layer IFM memory.
- It tracks pixel and filter indices and signals the controller when each filter pass and the whole layer are finished.

Parameters:
- DATA_WIDTH, 32, width of every data word (signed two's complement fixed point; partials and bias share one scale).
- IFM_SIZE_NEXT, 28, output feature map side length; IFM_SIZE_NEXT*IFM_SIZE_NEXT pixels per filter.
- NUMBER_OF_FILTERS, 6, number of output maps, each with one bias.
- NUMBER_OF_UNITS, 3, number of partial-sum inputs (equals IFM depth).
- ADDRESS_SIZE_OFM, $clog2(IFM_SIZE_NEXT*IFM_SIZE_NEXT*NUMBER_OF_FILTERS), output memory address width.
- BIAS_ADDR_BITS, $clog2(NUMBER_OF_FILTERS), bias register index width.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- riscv_data  in  DATA_WIDTH  bias load data.
- bias_write  in  1  writes riscv_data to bias[bias_address].
- bias_address  in  BIAS_ADDR_BITS  bias index; values >= NUMBER_OF_FILTERS are ignored.
- start  in  1  one-cycle pulse that begins a filter pass.
- in_valid  in  1  partial_sums holds one pixel's partials this cycle.
- partial_sums  in  NUMBER_OF_UNITS*DATA_WIDTH  unit k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- ofm_write_enable  out  1  write strobe to the next-layer memory.
- ofm_address  out  ADDRESS_SIZE_OFM  filter*IFM_SIZE_NEXT^2 + pixel.
- ofm_data  out  DATA_WIDTH  activated result.
- busy  out  1  high in RUN and DRAIN.
- filter_done  out  1  one-cycle pulse at the end of each filter pass.
- layer_done  out  1  one-cycle pulse at the end of the last filter's pass.

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs are 0; state is IDLE.
  - Pixel counter, filter index, pipeline valid bits and all bias registers are 0.
- Bias writes are accepted in any state and take effect on the next cycle. A bias write to the current filter during RUN is undefined usage.
- FSM IDLE:
  - start -> RUN with pixel counter = 0.
  - in_valid is ignored.
- FSM RUN:
  - Each in_valid cycle accepts one pixel and increments the pixel counter.
  - When the accepted pixel is number IFM_SIZE_NEXT^2-1 -> DRAIN.
  - start is ignored.
  - in_valid=0 stalls counting only; the pipeline keeps flowing.
- FSM DRAIN:
  - in_valid is ignored.
  - When both pipeline stages are empty -> IDLE, pulse filter_done for one cycle, and increment the filter index.
  - If the finished filter was NUMBER_OF_FILTERS-1, also pulse layer_done in the same cycle and wrap the filter index to 0.
- Pipeline, 2 stages, no backpressure:
  - S1 registers the sign-extended sum of all partials plus bias[filter] at width DATA_WIDTH+$clog2(NUMBER_OF_UNITS+1). It also registers the address.
  - S2 applies the activation: negative -> 0; above 2^(DATA_WIDTH-1)-1 -> clamp to 2^(DATA_WIDTH-1)-1; otherwise the low DATA_WIDTH bits.
  - S2 registers ofm_data and ofm_address, and raises ofm_write_enable for one cycle per accepted pixel.
- Latency: in_valid at edge n -> ofm_write_enable high after edge n+2. Throughput is 1 pixel/cycle.
- ofm_data and ofm_address hold their last values when ofm_write_enable=0.
- start and in_valid in the same cycle while IDLE: start is taken and in_valid is ignored.
- Reset asserted mid-pass: the pass is abandoned, no further writes occur, and the filter index returns to 0.

Test Plan:
- Reset, then bias[0]=5 and start. Drive 784 pixels with partials (1,2,3).
  -> 784 writes with ofm_data=11 and addresses 0..783.
  -> First write 2 cycles after the first in_valid.
  -> filter_done pulses once, after the final write; busy drops in the same cycle.
- Bias[1]=-100, partials (10,20,30), second pass.
  -> Every ofm_data=0 (ReLU).
  -> Addresses 784..1567.
- Partials (0x7FFFFFFF, 0x7FFFFFFF, 0x7FFFFFFF) with bias 0 -> ofm_data=0x7FFFFFFF (saturation).
- Six full passes.
  -> layer_done pulses exactly once, coincident with the 6th filter_done.
  -> Last address is 4703.
  -> A 7th pass writes starting at address 0.
- in_valid toggling 1/0 with start asserted mid-RUN.
  -> Exactly 784 writes.
  -> No restart and no gaps in addresses.
- Assert reset after 100 accepted pixels.
  -> Outputs drop to 0 immediately (asynchronous).
  -> No writes until the next start.
  -> The next pass begins at address 0.

Source files
------------

// File: rtl/conv_a1_accumulate_relu.sv
// Accumulates the per-unit partial sums of one output pixel, adds the filter
// bias, applies a saturating ReLU and writes the result into the next-layer
// feature-map memory. It also tracks pixel and filter progress for the controller.
module conv_a1_accumulate_relu #(
  parameter int DATA_WIDTH        = 32,
  parameter int IFM_SIZE_NEXT     = 28,
  parameter int NUMBER_OF_FILTERS = 6,
  parameter int NUMBER_OF_UNITS   = 3,
  parameter int ADDRESS_SIZE_OFM  = $clog2(IFM_SIZE_NEXT*IFM_SIZE_NEXT*NUMBER_OF_FILTERS),
  parameter int BIAS_ADDR_BITS    = $clog2(NUMBER_OF_FILTERS)
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [DATA_WIDTH-1:0]                 riscv_data,
  input  logic                                  bias_write,
  input  logic [BIAS_ADDR_BITS-1:0]             bias_address,
  input  logic                                  start,
  input  logic                                  in_valid,
  input  logic [NUMBER_OF_UNITS*DATA_WIDTH-1:0] partial_sums,
  output logic                                  ofm_write_enable,
  output logic [ADDRESS_SIZE_OFM-1:0]           ofm_address,
  output logic [DATA_WIDTH-1:0]                 ofm_data,
  output logic                                  busy,
  output logic                                  filter_done,
  output logic                                  layer_done
);

  localparam int PIXELS = IFM_SIZE_NEXT * IFM_SIZE_NEXT;
  localparam int PIX_W  = (PIXELS > 1) ? $clog2(PIXELS) : 1;
  localparam int SUM_W  = DATA_WIDTH + $clog2(NUMBER_OF_UNITS + 1);

  localparam logic [PIX_W-1:0]            LAST_PIXEL   = PIX_W'(PIXELS - 1);
  localparam logic [BIAS_ADDR_BITS-1:0]   LAST_FILTER  = BIAS_ADDR_BITS'(NUMBER_OF_FILTERS - 1);
  localparam logic [BIAS_ADDR_BITS:0]     FILTER_COUNT = (BIAS_ADDR_BITS + 1)'(NUMBER_OF_FILTERS);
  localparam logic [ADDRESS_SIZE_OFM-1:0] PIXELS_A     = ADDRESS_SIZE_OFM'(PIXELS);
  localparam logic signed [SUM_W-1:0]     SAT_MAX      =
    {{(SUM_W - DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                          state;
  state_t                          state_next;
  logic [PIX_W-1:0]                pixel_count;
  logic [BIAS_ADDR_BITS-1:0]       filter_idx;
  logic signed [DATA_WIDTH-1:0]    bias [NUMBER_OF_FILTERS];
  logic                            s1_valid;
  logic signed [SUM_W-1:0]         s1_sum;
  logic [ADDRESS_SIZE_OFM-1:0]     s1_addr;
  logic signed [SUM_W-1:0]         sum_next;
  logic [ADDRESS_SIZE_OFM-1:0]     addr_next;
  logic [DATA_WIDTH-1:0]           act_value;
  logic                            accept;
  logic                            last_accept;
  logic                            drain_done;

  assign accept      = (state == RUN) && in_valid;
  assign last_accept = accept && (pixel_count == LAST_PIXEL);
  assign drain_done  = (state == DRAIN) && !s1_valid && !ofm_write_enable;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic: a pass runs until the last pixel is taken, then waits for the pipeline to empty
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start)       state_next = RUN;
      RUN:     if (last_accept) state_next = DRAIN;
      DRAIN:   if (drain_done)  state_next = IDLE;
      default:                  state_next = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state == RUN) || (state == DRAIN);
  end

  // Pixel counter restarts on start and advances once per accepted pixel
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pixel_count <= '0;
    end else if ((state == IDLE) && start) begin
      pixel_count <= '0;
    end else if (accept) begin
      pixel_count <= last_accept ? '0 : pixel_count + PIX_W'(1);
    end
  end

  // Completion pulses and filter index, advanced as the drained pass returns to IDLE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      filter_idx  <= '0;
      filter_done <= 1'b0;
      layer_done  <= 1'b0;
    end else begin
      filter_done <= drain_done;
      layer_done  <= drain_done && (filter_idx == LAST_FILTER);
      if (drain_done) filter_idx <= (filter_idx == LAST_FILTER) ? '0 : filter_idx + BIAS_ADDR_BITS'(1);
    end
  end

  // Bias register file, writable in any state; out-of-range indices are dropped
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUMBER_OF_FILTERS; i++) bias[i] <= '0;
    end else if (bias_write && ({1'b0, bias_address} < FILTER_COUNT)) begin
      bias[bias_address] <= riscv_data;
    end
  end

  // Sign-extended sum of all partials plus the current filter bias, and the output address
  always_comb begin
    sum_next = {{(SUM_W - DATA_WIDTH){bias[filter_idx][DATA_WIDTH-1]}}, bias[filter_idx]};
    for (int k = 0; k < NUMBER_OF_UNITS; k++) begin
      sum_next = sum_next + {{(SUM_W - DATA_WIDTH){partial_sums[k*DATA_WIDTH + DATA_WIDTH - 1]}},
                             partial_sums[k*DATA_WIDTH +: DATA_WIDTH]};
    end
    addr_next = ADDRESS_SIZE_OFM'(filter_idx) * PIXELS_A + ADDRESS_SIZE_OFM'(pixel_count);
  end

  // Stage 1 captures the wide sum and its address
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_sum   <= '0;
      s1_addr  <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_sum  <= sum_next;
        s1_addr <= addr_next;
      end
    end
  end

  // Saturating ReLU on the stage-1 sum
  always_comb begin
    act_value = s1_sum[DATA_WIDTH-1:0];
    if (s1_sum[SUM_W-1])       act_value = '0;
    else if (s1_sum > SAT_MAX) act_value = SAT_MAX[DATA_WIDTH-1:0];
  end

  // Stage 2 drives the memory write; data and address hold between writes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ofm_write_enable <= 1'b0;
      ofm_data         <= '0;
      ofm_address      <= '0;
    end else begin
      ofm_write_enable <= s1_valid;
      if (s1_valid) begin
        ofm_data    <= act_value;
        ofm_address <= s1_addr;
      end
    end
  end

endmodule

// File: tb/tb_conv_a1_accumulate_relu.sv
// Randomized bench for conv_a1_accumulate_relu with an arithmetic reference model
// and a queue of expected memory writes.
module tb_conv_a1_accumulate_relu;

  localparam int DW     = 32;
  localparam int SIDE   = 28;
  localparam int NF     = 6;
  localparam int NU     = 3;
  localparam int PIXELS = SIDE * SIDE;
  localparam int AW     = $clog2(PIXELS * NF);
  localparam int BW     = $clog2(NF);

  logic             clk = 1'b0;
  logic             reset;
  logic [DW-1:0]    riscv_data;
  logic             bias_write;
  logic [BW-1:0]    bias_address;
  logic             start;
  logic             in_valid;
  logic [NU*DW-1:0] partial_sums;
  logic             ofm_write_enable;
  logic [AW-1:0]    ofm_address;
  logic [DW-1:0]    ofm_data;
  logic             busy;
  logic             filter_done;
  logic             layer_done;

  conv_a1_accumulate_relu #(
    .DATA_WIDTH(DW), .IFM_SIZE_NEXT(SIDE), .NUMBER_OF_FILTERS(NF), .NUMBER_OF_UNITS(NU)
  ) dut (
    .clk(clk), .reset(reset), .riscv_data(riscv_data), .bias_write(bias_write),
    .bias_address(bias_address), .start(start), .in_valid(in_valid),
    .partial_sums(partial_sums), .ofm_write_enable(ofm_write_enable),
    .ofm_address(ofm_address), .ofm_data(ofm_data), .busy(busy),
    .filter_done(filter_done), .layer_done(layer_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint addr;
    longint data;
    longint due;
  } exp_t;

  int     tests_run = 0;
  int     tests_failed = 0;
  longint cycle = 0;
  longint bias_m [NF];
  int     model_filter;
  exp_t   exp_q [$];
  int     pass_writes;
  longint first_addr;
  longint last_addr;
  longint last_write_cycle;
  int     done_pulses = 0;
  int     layer_pulses = 0;

  // Cycle count used for latency expectations
  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string tag, input longint actual, input longint expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  function automatic longint relu(input longint s);
    if (s < 0) return 0;
    if (s > 64'sd2147483647) return 64'sd2147483647;
    return s;
  endfunction

  // Monitor: every write must match the oldest expected pixel, address and arrival cycle
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      if (ofm_write_enable) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_write", 1, 0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("ofm_address", longint'(ofm_address), e.addr);
          checkOutput("ofm_data", longint'(ofm_data), e.data);
          checkOutput("write_latency", cycle, e.due);
        end
        if (pass_writes == 0) first_addr = longint'(ofm_address);
        last_addr        = longint'(ofm_address);
        last_write_cycle = cycle;
        pass_writes++;
      end
      if (filter_done) done_pulses++;
      if (layer_done)  layer_pulses++;
    end
  end

  task automatic write_bias(input int idx, input int value);
    @(posedge clk); #1;
    bias_write   = 1'b1;
    bias_address = BW'(idx);
    riscv_data   = value;
    @(posedge clk); #1;
    bias_write = 1'b0;
    if (idx < NF) bias_m[idx] = value;
  endtask

  // mode 0: fixed partials a,b,c; 1: full-range random; 2: small random
  task automatic applyStimulus(input int mode, input int a, input int b, input int c,
                               input bit toggle, input int pixel_limit);
    int   p0, p1, p2;
    exp_t e;
    bit   seen;
    pass_writes = 0;
    @(posedge clk); #1;
    start        = 1'b1;
    in_valid     = toggle;
    partial_sums = '1;
    @(posedge clk); #1;
    start    = 1'b0;
    in_valid = 1'b0;
    for (int p = 0; p < pixel_limit; p++) begin
      if (toggle) begin
        in_valid = 1'b0;
        start    = (p == 300);
        @(posedge clk); #1;
        start = 1'b0;
      end
      case (mode)
        0:       begin p0 = a; p1 = b; p2 = c; end
        1:       begin p0 = int'($urandom); p1 = int'($urandom); p2 = int'($urandom); end
        default: begin
          p0 = int'($urandom_range(2000)) - 1000;
          p1 = int'($urandom_range(2000)) - 1000;
          p2 = int'($urandom_range(2000)) - 1000;
        end
      endcase
      partial_sums = {p2, p1, p0};
      in_valid     = 1'b1;
      e.addr = longint'(model_filter) * PIXELS + p;
      e.data = relu(bias_m[model_filter] + longint'(p0) + longint'(p1) + longint'(p2));
      e.due  = cycle + 2;
      exp_q.push_back(e);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (pixel_limit >= PIXELS) begin
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(negedge clk);
        if (filter_done) seen = 1'b1;
      end
      checkOutput("filter_done_seen", seen, 1);
      checkOutput("busy_at_done", busy, 0);
      checkOutput("layer_done", layer_done, (model_filter == NF - 1));
      checkOutput("pass_writes", pass_writes, PIXELS);
      checkOutput("done_after_last_write", (cycle > last_write_cycle), 1);
      checkOutput("queue_drained", exp_q.size(), 0);
      @(negedge clk);
      checkOutput("filter_done_single", filter_done, 0);
      model_filter = (model_filter + 1) % NF;
    end
  endtask

  // Watchdog so the run always ends
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int v;
    reset        = 1'b0;
    start        = 1'b0;
    in_valid     = 1'b0;
    bias_write   = 1'b0;
    bias_address = '0;
    riscv_data   = '0;
    partial_sums = '0;
    for (int i = 0; i < NF; i++) bias_m[i] = 0;
    model_filter = 0;

    #12;
    checkOutput("rst_write_enable", ofm_write_enable, 0);
    checkOutput("rst_address", ofm_address, 0);
    checkOutput("rst_data", ofm_data, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_filter_done", filter_done, 0);
    checkOutput("rst_layer_done", layer_done, 0);
    @(posedge clk); #1;
    reset = 1'b1;

    write_bias(7, 1234);
    write_bias(0, 5);
    applyStimulus(0, 1, 2, 3, 1'b0, PIXELS);
    checkOutput("pass1_first_addr", first_addr, 0);
    checkOutput("pass1_last_addr", last_addr, PIXELS - 1);

    write_bias(1, -100);
    applyStimulus(0, 10, 20, 30, 1'b0, PIXELS);
    checkOutput("pass2_first_addr", first_addr, PIXELS);
    checkOutput("pass2_last_addr", last_addr, 2 * PIXELS - 1);

    write_bias(2, 0);
    applyStimulus(0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, PIXELS);

    for (int f = 3; f < NF; f++) begin
      v = int'($urandom);
      write_bias(f, v);
      applyStimulus(1, 0, 0, 0, 1'b0, PIXELS);
    end
    checkOutput("layer_last_addr", last_addr, NF * PIXELS - 1);
    checkOutput("layer_pulses", layer_pulses, 1);
    checkOutput("done_pulses", done_pulses, NF);

    applyStimulus(1, 0, 0, 0, 1'b1, PIXELS);
    checkOutput("pass7_first_addr", first_addr, 0);
    checkOutput("pass7_layer_pulses", layer_pulses, 1);

    applyStimulus(2, 0, 0, 0, 1'b0, 100);
    #1;
    reset = 1'b0;
    exp_q.delete();
    model_filter = 0;
    for (int i = 0; i < NF; i++) bias_m[i] = 0;
    #1;
    checkOutput("midrst_write_enable", ofm_write_enable, 0);
    checkOutput("midrst_address", ofm_address, 0);
    checkOutput("midrst_data", ofm_data, 0);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_filter_done", filter_done, 0);
    checkOutput("midrst_layer_done", layer_done, 0);
    @(posedge clk); #1;
    reset       = 1'b1;
    pass_writes = 0;
    for (int i = 0; i < 12; i++) begin
      in_valid     = $urandom_range(1);
      partial_sums = {$urandom, $urandom, $urandom};
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("postrst_no_writes", pass_writes, 0);
    checkOutput("postrst_busy", busy, 0);

    applyStimulus(2, 0, 0, 0, 1'b0, PIXELS);
    checkOutput("postrst_first_addr", first_addr, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
